// File: rtl/irq_pend_ctrl.sv
// Pending-interrupt capture and fixed-priority presentation (bit 7 highest, no preemption).
// Optional macro IRQ_MASK_EN adds a per-bit mask port that gates presentation only.
module irq_pend_ctrl #(
    parameter int unsigned EDGE_DET = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic [7:0] Din,
`ifdef IRQ_MASK_EN
    input  logic [7:0] mask,
`endif
    input  logic       ack,
    output logic [2:0] Y,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic {StIdle, StPresent} state_e;

    state_e     state_q, state_d;
    logic [7:0] din_q, pending_q, pending_d;
    logic [2:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic       overflow_q, overflow_d;
    logic [7:0] cap, set, clr, elig;

    always_comb begin
        cap = (EDGE_DET != 0) ? (Din & ~din_q) : Din;
        set = cap & {8{EN}};
    end

`ifdef IRQ_MASK_EN
    assign elig = pending_q & mask;
`else
    assign elig = pending_q;
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        valid_d = valid_q;
        clr     = 8'h00;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                y_d     = 3'b000;
                if (elig != 8'h00) begin
                    // Ascending scan: the last hit is the highest set index.
                    for (int i = 0; i < 8; i++) begin
                        if (elig[i]) y_d = 3'(i);
                    end
                    valid_d = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (ack) begin
                    clr       = 8'h00;
                    clr[y_q]  = 1'b1;
                    valid_d   = 1'b0;
                    y_d       = 3'b000;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Set wins over clear; a capture on a bit being cleared this cycle is not a loss.
    always_comb begin
        pending_d  = (pending_q & ~clr) | set;
        overflow_d = |(set & pending_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            din_q      <= 8'hFF;
            pending_q  <= 8'h00;
            y_q        <= 3'b000;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            din_q      <= Din;
            pending_q  <= pending_d;
            y_q        <= y_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign Y        = y_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Directed spec scenarios followed by random traffic, checked against a behavioural model.
module tb_irq_pend_ctrl;

    logic       clk = 1'b0;
    logic       rst, EN, ack;
    logic [7:0] Din, mask;
    logic [2:0] Y;
    logic       valid, overflow;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending flags, presented index (-1 = none).
    bit m_pend [8];
    bit m_prev [8];
    int m_cur;
    bit m_ovf;

    always #5 clk = ~clk;

    irq_pend_ctrl #(.EDGE_DET(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .EN       (EN),
        .Din      (Din),
`ifdef IRQ_MASK_EN
        .mask     (mask),
`endif
        .ack      (ack),
        .Y        (Y),
        .valid    (valid),
        .pending  (pending),
        .overflow (overflow)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic int model_pend_vec();
        int v = 0;
        for (int i = 0; i < 8; i++) if (m_pend[i]) v += (1 << i);
        return v;
    endfunction

    task automatic model_step();
        bit cap [8];
        bit nxt [8];
        int clr_idx;
        int best;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0;
                m_prev[i] = 1;
            end
            m_cur = -1;
            m_ovf = 0;
            return;
        end
        clr_idx = (m_cur >= 0 && ack) ? m_cur : -1;
        m_ovf = 0;
        for (int i = 0; i < 8; i++) begin
            cap[i] = EN && Din[i] && !m_prev[i];
            if (cap[i] && m_pend[i] && i != clr_idx) m_ovf = 1;
            nxt[i] = cap[i] || (m_pend[i] && i != clr_idx);
        end
        if (m_cur >= 0) begin
            if (ack) m_cur = -1;
        end else begin
            best = -1;
            for (int i = 0; i < 8; i++) begin
`ifdef IRQ_MASK_EN
                if (m_pend[i] && mask[i]) best = i;
`else
                if (m_pend[i]) best = i;
`endif
            end
            m_cur = best;
        end
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = nxt[i];
            m_prev[i] = Din[i];
        end
    endtask

    // Apply inputs for one cycle, advance the model, then compare #1 after the edge.
    task automatic cyc(input logic [7:0] d, input logic e, input logic a, input logic r);
        Din = d;
        EN  = e;
        ack = a;
        rst = r;
        @(posedge clk);
        model_step();
        #1;
        check("pending", int'(pending), model_pend_vec());
        check("valid", int'(valid), (m_cur >= 0) ? 1 : 0);
        check("Y", int'(Y), (m_cur >= 0) ? m_cur : 0);
        check("overflow", int'(overflow), int'(m_ovf));
    endtask

    initial begin
        m_cur = -1;
        mask  = 8'hFF;

        // Reset then priority order 5 before 2, with bubble.
        cyc(8'h00, 1, 0, 1);
        check("rst_pending", int'(pending), 0);
        check("rst_valid", int'(valid), 0);
        cyc(8'h00, 1, 0, 0);
        cyc(8'h24, 1, 0, 0);
        check("cap_24", int'(pending), 'h24);
        check("cap_24_valid", int'(valid), 0);
        cyc(8'h24, 1, 0, 0);
        check("present_5", int'(Y), 5);
        cyc(8'h24, 1, 1, 0);
        check("bubble", int'(valid), 0);
        cyc(8'h24, 1, 0, 0);
        check("present_2", int'(Y), 2);

        // No preemption by bit 7.
        cyc(8'hA4, 1, 0, 0);
        check("no_preempt", int'(Y), 2);
        cyc(8'hA4, 1, 1, 0);
        cyc(8'hA4, 1, 0, 0);
        check("present_7", int'(Y), 7);
        cyc(8'hA4, 1, 1, 0);
        check("drained", int'(pending), 0);
        cyc(8'h24, 1, 0, 0);
        check("drained_valid", int'(valid), 0);

        // Set beats clear; overflow on a repeat edge without ack.
        cyc(8'h00, 1, 0, 0);
        cyc(8'h08, 1, 0, 0);
        cyc(8'h00, 1, 0, 0);
        check("present_3", int'(Y), 3);
        cyc(8'h08, 1, 1, 0);
        check("set_wins", int'(pending), 'h08);
        check("set_wins_ovf", int'(overflow), 0);
        cyc(8'h00, 1, 0, 0);
        cyc(8'h00, 1, 0, 0);
        check("represent_3", int'(Y), 3);
        cyc(8'h08, 1, 0, 0);
        check("ovf_pulse", int'(overflow), 1);
        cyc(8'h00, 1, 0, 0);
        check("ovf_one_cycle", int'(overflow), 0);
        cyc(8'h00, 1, 1, 0);

        // EN low: retain, present, clear; no capture when EN rises on a high line.
        cyc(8'h10, 1, 0, 0);
        cyc(8'h00, 1, 0, 0);
        cyc(8'hFF, 0, 0, 0);
        cyc(8'h00, 0, 0, 0);
        cyc(8'hFF, 0, 0, 0);
        check("en0_hold", int'(pending), 'h10);
        check("en0_present", int'(Y), 4);
        cyc(8'h01, 0, 1, 0);
        check("en0_clear", int'(pending), 0);
        cyc(8'h01, 0, 0, 0);
        cyc(8'h01, 1, 0, 0);
        check("en_rise_nocap", int'(pending), 0);

        // Reset dominates ack while presenting; high line across reset is not an edge.
        cyc(8'h80, 1, 0, 0);
        cyc(8'h80, 1, 0, 0);
        cyc(8'h80, 1, 1, 1);
        check("rst_mid_valid", int'(valid), 0);
        check("rst_mid_pend", int'(pending), 0);
        cyc(8'h80, 1, 0, 0);
        cyc(8'h80, 1, 0, 0);
        check("no_cap_after_rst", int'(pending), 0);

`ifdef IRQ_MASK_EN
        mask = 8'h0F;
        cyc(8'h00, 1, 0, 0);
        cyc(8'h90, 1, 0, 0);
        cyc(8'h90, 1, 0, 0);
        check("masked_pend", int'(pending), 'h90);
        check("masked_valid", int'(valid), 0);
        mask = 8'hFF;
        cyc(8'h90, 1, 0, 0);
        check("unmasked_7", int'(Y), 7);
        cyc(8'h90, 1, 1, 0);
        cyc(8'h00, 1, 0, 0);
        cyc(8'h00, 1, 1, 0);
`endif

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
`ifdef IRQ_MASK_EN
            mask = 8'($urandom);
`endif
            cyc(8'($urandom), ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
